// File: rtl/i2s_receiver_if.sv
// i2s_receiver_if: bundles the I2S receive-side signals.
//   master : stream source / sample consumer (drives onOff, SCLK, LRCLK, SD; reads Rx, Valid, Error)
//   slave  : the receiver (reads the serial inputs, drives the parallel sample outputs)
//   onOff  receive enable
//   SCLK   I2S bit clock (asynchronous to the system clock)
//   LRCLK  word select, 0 = left, 1 = right
//   SD     serial data, MSB first
//   Rx     last complete frame {left, right}, 2*WIDTH bits
//   Valid  one-cycle strobe when Rx updates
//   Error  with Valid: one slot of the frame was shorter than WIDTH bits
interface i2s_receiver_if #(
  parameter int WIDTH = 16
);
  logic               onOff;
  logic               SCLK;
  logic               LRCLK;
  logic               SD;
  logic [2*WIDTH-1:0] Rx;
  logic               Valid;
  logic               Error;

  modport master (
    output onOff, SCLK, LRCLK, SD,
    input  Rx, Valid, Error
  );

  modport slave (
    input  onOff, SCLK, LRCLK, SD,
    output Rx, Valid, Error
  );
endinterface

// File: rtl/i2s_receiver.sv
// i2s_receiver: oversampling I2S receiver. SCLK, LRCLK and SD are synchronised
// into the Clock domain; every SCLK rising edge samples one bit. One left and
// one right slot are deserialised and emitted together as {left, right} with a
// one-cycle Valid strobe. Nothing is clocked by SCLK.
//
// Ports:
//   Clock  system clock, rising edge
//   Reset  asynchronous, active-high
//   bus    i2s_receiver_if.slave (onOff, SCLK, LRCLK, SD in; Rx, Valid, Error out)
//
// Build option:
//   I2S_RX_ONE_BIT_DELAY_EN defined   : standard I2S, the bit sampled on a word
//                                       select change is the LSB of the closing slot.
//   I2S_RX_ONE_BIT_DELAY_EN undefined : left-justified, that bit is the MSB of
//                                       the new slot.
module i2s_receiver #(
  parameter int WIDTH = 16
) (
  input  logic          Clock,
  input  logic          Reset,
  i2s_receiver_if.slave bus
);

  localparam int               CNT_W   = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, SYNC, LEFT, RIGHT} state_t;

  // Writes bit b at MSB-first position cnt; positions at or beyond WIDTH are dropped.
  function automatic logic [WIDTH-1:0] put_bit(input logic [WIDTH-1:0] word,
                                               input logic [CNT_W-1:0] cnt,
                                               input logic             b);
    logic [WIDTH-1:0] r;
    r = word;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt == CNT_W'(i)) r[WIDTH-1-i] = b;
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  endfunction

  state_t             state_q, state_d;
  logic [2:0]         sclk_sync_q, sclk_sync_d;
  logic [1:0]         lr_sync_q, lr_sync_d;
  logic [1:0]         sd_sync_q, sd_sync_d;
  logic               lr_prev_q, lr_prev_d;
  logic               lr_ok_q, lr_ok_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic               hold_short_q, hold_short_d;
  logic [2*WIDTH-1:0] rx_q, rx_d;
  logic               valid_q, valid_d;
  logic               error_q, error_d;

  logic               sclk_rise;
  logic               lr;
  logic               sd;
  logic               boundary;
  logic [WIDTH-1:0]   close_word;
  logic [CNT_W-1:0]   close_cnt;
  logic [WIDTH-1:0]   open_word;
  logic [CNT_W-1:0]   open_cnt;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign lr        = lr_sync_q[1];
  assign sd        = sd_sync_q[1];
  // lr_ok_q keeps the reset value of lr_prev from faking a 1->0 boundary when
  // reset is released in the middle of a left slot.
  assign boundary  = sclk_rise & lr_ok_q & (lr != lr_prev_q);

  always_comb begin
    state_d      = state_q;
    sclk_sync_d  = {sclk_sync_q[1:0], bus.SCLK};
    lr_sync_d    = {lr_sync_q[0], bus.LRCLK};
    sd_sync_d    = {sd_sync_q[0], bus.SD};
    lr_prev_d    = lr_prev_q;
    lr_ok_d      = lr_ok_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    hold_short_d = hold_short_q;
    rx_d         = rx_q;
    valid_d      = 1'b0;
    error_d      = 1'b0;

`ifdef I2S_RX_ONE_BIT_DELAY_EN
    // The boundary bit still belongs to the slot being closed.
    close_word = put_bit(shift_q, cnt_q, sd);
    close_cnt  = sat_inc(cnt_q);
    open_word  = '0;
    open_cnt   = '0;
`else
    // The boundary bit is the MSB of the slot being opened.
    close_word = shift_q;
    close_cnt  = cnt_q;
    open_word  = put_bit('0, '0, sd);
    open_cnt   = CNT_W'(1);
`endif

    // Word select history is tracked even while idle so that re-enabling
    // mid-slot cannot see a stale boundary.
    if (sclk_rise) begin
      lr_prev_d = lr;
      lr_ok_d   = 1'b1;
    end

    if (!bus.onOff) begin
      state_d = IDLE;
      shift_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE:  state_d = SYNC;
        SYNC:  if (boundary && !lr) state_d = LEFT;
        LEFT: begin
          if (boundary && lr) begin
            state_d      = RIGHT;
            hold_d       = close_word;
            hold_short_d = (close_cnt != CNT_MAX);
          end
        end
        RIGHT: begin
          if (boundary && !lr) begin
            state_d = LEFT;
            rx_d    = {hold_q, close_word};
            valid_d = 1'b1;
            error_d = hold_short_q | (close_cnt != CNT_MAX);
          end
        end
        default: state_d = IDLE;
      endcase

      if (state_q != IDLE && sclk_rise) begin
        if (boundary) begin
          shift_d = open_word;
          cnt_d   = open_cnt;
        end else begin
          shift_d = put_bit(shift_q, cnt_q, sd);
          cnt_d   = sat_inc(cnt_q);
        end
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      sclk_sync_q  <= '0;
      lr_sync_q    <= '0;
      sd_sync_q    <= '0;
      lr_prev_q    <= 1'b1;
      lr_ok_q      <= 1'b0;
      shift_q      <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      hold_short_q <= 1'b0;
      rx_q         <= '0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sclk_sync_q  <= sclk_sync_d;
      lr_sync_q    <= lr_sync_d;
      sd_sync_q    <= sd_sync_d;
      lr_prev_q    <= lr_prev_d;
      lr_ok_q      <= lr_ok_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      hold_short_q <= hold_short_d;
      rx_q         <= rx_d;
      valid_q      <= valid_d;
      error_q      <= error_d;
    end
  end

  assign bus.Rx    = rx_q;
  assign bus.Valid = valid_q;
  assign bus.Error = error_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: drives an I2S stream (Clock = 8 x SCLK) into i2s_receiver
// and compares every emitted frame against a scoreboard of expected frames.
// Follows I2S_RX_ONE_BIT_DELAY_EN the same way as the design build.
module tb_i2s_receiver;

  localparam int WIDTH = 16;
  localparam int HALF  = 4;

  logic Clock;
  logic Reset;

  i2s_receiver_if #(.WIDTH(WIDTH)) bus ();

  i2s_receiver #(.WIDTH(WIDTH)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;
  int nvalid   = 0;
  int npushed  = 0;
  logic [32:0] sb[$];
`ifdef I2S_RX_ONE_BIT_DELAY_EN
  logic prev_sd = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected slot content: left-aligned, zero padded when short, truncated when long.
  function automatic logic [15:0] slot_word(input logic [31:0] v, input int n);
    logic [31:0] t;
    if (n >= 16) t = v >> (n - 16);
    else         t = v << (16 - n);
    return t[15:0];
  endfunction

  // One SCLK period, entered and left on a falling Clock edge. With pulse_off,
  // onOff is low only for the edge that acts on this period's SCLK rise.
  task automatic sclk_period(input logic lr, input logic sd, input bit pulse_off);
    bus.SCLK  = 1'b0;
    bus.LRCLK = lr;
    bus.SD    = sd;
    repeat (HALF) @(negedge Clock);
    bus.SCLK = 1'b1;
    if (pulse_off) begin
      repeat (2) @(negedge Clock);
      bus.onOff = 1'b0;
      @(negedge Clock);
      bus.onOff = 1'b1;
      @(negedge Clock);
    end else begin
      repeat (HALF) @(negedge Clock);
    end
  endtask

  // Sends MSB-first bits lo..hi-1 of an n-bit slot value on word select lr.
  task automatic send_bits(input logic lr, input logic [31:0] v, input int n,
                           input int lo, input int hi, input bit pulse_first = 1'b0);
    for (int i = lo; i < hi; i++) begin
`ifdef I2S_RX_ONE_BIT_DELAY_EN
      sclk_period(lr, prev_sd, pulse_first && (i == lo));
      prev_sd = v[n-1-i];
`else
      sclk_period(lr, v[n-1-i], pulse_first && (i == lo));
`endif
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n, input bit expect_out);
    send_bits(1'b0, l, n, 0, n);
    send_bits(1'b1, r, n, 0, n);
    if (expect_out) begin
      sb.push_back({slot_word(l, n), slot_word(r, n), (n < 16)});
      npushed++;
    end
  endtask

  // Enable in the middle of a right slot so the next frame starts aligned.
  task automatic resync();
    bus.onOff = 1'b0;
    send_bits(1'b1, 32'h0, 16, 0, 8);
    bus.onOff = 1'b1;
    send_bits(1'b1, 32'h0, 16, 8, 16);
  endtask

  // Opens a left slot so the last right slot closes, then disables.
  task automatic tail();
    send_bits(1'b0, 32'h0, 16, 0, 3);
    repeat (4) @(negedge Clock);
    bus.onOff = 1'b0;
  endtask

  // Output monitor / scoreboard.
  initial begin
    logic        prev_v;
    logic [32:0] e;
    prev_v = 1'b0;
    forever begin
      @(negedge Clock);
      if (!Reset && bus.Valid) begin
        nvalid++;
        check("valid_width", prev_v, 1'b0);
        if (sb.size() == 0) begin
          check("unexpected_valid", bus.Rx, 0);
        end else begin
          e = sb.pop_front();
          check("rx", bus.Rx, e[32:1]);
          check("error", bus.Error, e[0]);
        end
      end else if (prev_v) begin
        check("error_after_valid", bus.Error, 1'b0);
      end
      prev_v = bus.Valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    Reset     = 1'b1;
    bus.onOff = 1'b0;
    bus.SCLK  = 1'b0;
    bus.LRCLK = 1'b1;
    bus.SD    = 1'b0;
    repeat (3) @(negedge Clock);
    check("reset_rx", bus.Rx, 0);
    check("reset_valid", bus.Valid, 0);
    check("reset_error", bus.Error, 0);
    Reset = 1'b0;
    @(negedge Clock);

    // Nominal frame.
    v0 = nvalid;
    resync();
    send_frame(32'hA5C3, 32'h3C5A, 16, 1'b1);
    tail();
    check("nominal_valids", nvalid - v0, 1);
    check("nominal_hold_rx", bus.Rx, 32'hA5C33C5A);

    // Startup discard: enabled mid-right-slot of frame 1.
    v0 = nvalid;
    send_bits(1'b0, 32'h1234, 16, 0, 16);
    send_bits(1'b1, 32'h5678, 16, 0, 8);
    bus.onOff = 1'b1;
    send_bits(1'b1, 32'h5678, 16, 8, 16);
    send_frame(32'h0F0F, 32'hF0F0, 16, 1'b1);
    send_frame(32'h8001, 32'h7FFE, 16, 1'b1);
    tail();
    check("startup_valids", nvalid - v0, 2);

    // Short slots.
    v0 = nvalid;
    resync();
    send_frame(32'hFFF, 32'hFFF, 12, 1'b1);
    tail();
    check("short_valids", nvalid - v0, 1);

    // Long slots.
    v0 = nvalid;
    resync();
    send_frame(32'h2AAAA, 32'h15555, 18, 1'b1);
    tail();
    check("long_valids", nvalid - v0, 1);

    // Reset mid-left-slot.
    v0 = nvalid;
    resync();
    send_frame(32'h1111, 32'h2222, 16, 1'b1);
    send_bits(1'b0, 32'h3333, 16, 0, 5);
    check("pre_reset_rx", bus.Rx, 32'h11112222);
    Reset = 1'b1;
    #1;
    check("mid_reset_rx", bus.Rx, 0);
    check("mid_reset_valid", bus.Valid, 0);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    send_bits(1'b0, 32'h3333, 16, 5, 16);
    send_bits(1'b1, 32'h4444, 16, 0, 16);
    send_frame(32'h5555, 32'h6666, 16, 1'b1);
    tail();
    check("reset_valids", nvalid - v0, 2);

    // onOff low on the exact right->left boundary edge.
    v0 = nvalid;
    resync();
    send_frame(32'h7777, 32'h8888, 16, 1'b0);
    send_bits(1'b0, 32'h9999, 16, 0, 16, 1'b1);
    send_bits(1'b1, 32'hAAAA, 16, 0, 16);
    send_frame(32'hBBBB, 32'hCCCC, 16, 1'b1);
    tail();
    check("off_valids", nvalid - v0, 1);

    repeat (20) @(negedge Clock);
    check("sb_drain", sb.size(), 0);
    check("valid_total", nvalid, npushed);
    check("idle_valid", bus.Valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
